sfu_commit_arbiter: RTL and testbench
=====================================

# sfu_commit_arbiter

Packet-aware round-robin arbiter that merges commit responses from the SFU sub-units (warp control, CSR, TI, and optional TEX/RASTER/OM agents) into the single SFU commit stream ahead of the gather stage. Multi-beat responses are held atomically: once an input starts a packet, it keeps the grant until the `eop` beat. A 2-entry output buffer registers the output. This keeps upstream `ready` independent of downstream `ready_out` while sustaining one beat per cycle.

## Interface
- `NUM_INPUTS`, default 6: number of requesters; valid range 1..16.
- `DATAW`, default 64: payload width per beat, excluding `eop`.
- `SEL_W`, derived: `max(1, clog2(NUM_INPUTS))`.

- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-low.
- `valid_in`  in  NUM_INPUTS  per-input beat valid.
- `ready_in`  out  NUM_INPUTS  per-input beat accepted.
- `data_in`  in  NUM_INPUTS×DATAW  per-input payload.
- `eop_in`  in  NUM_INPUTS  last beat of packet (1 = single-beat packet).
- `valid_out`  out  1  output beat valid.
- `ready_out`  in  1  downstream accept.
- `data_out`  out  DATAW  output payload.
- `eop_out`  out  1  output last-beat flag.
- `sel_out`  out  SEL_W  source index of the output beat.
- `busy`  out  1  buffer non-empty or a packet lock is held.

## Operation
- State:
  - `rr_ptr` (SEL_W): round-robin priority start.
  - `locked` (1) and `lock_idx` (SEL_W): packet lock.
  - 2-entry FIFO of {data, eop, sel} with `count` (0..2).
- Grant, combinational:
  - When `locked`, the candidate is `lock_idx` only.
  - Otherwise the candidate is the first `i` with `valid_in[i]`, scanning `rr_ptr`, `rr_ptr+1`, …, wrapping mod `NUM_INPUTS`.
- `space = (count < 2)`, derived from registered state only; no combinational path from `ready_out` to `ready_in`.
- `ready_in[i] = space && candidate==i && valid_in[i]`. At most one bit is set. All bits are 0 while `reset` is low.
- Accept (push): any `ready_in[i]` high. Pushes {`data_in[i]`, `eop_in[i]`, `i`}.
- Lock rules:
  - Accepted beat with eop=0 sets `locked=1`, `lock_idx=i`.
  - Accepted beat with eop=1 clears `locked`.
  - While locked and `valid_in[lock_idx]`=0, no other input is granted; the lock holds indefinitely.
- Pointer rule: on an accepted eop=1 beat from `i`, `rr_ptr <= (i+1) mod NUM_INPUTS`. Pointer is unchanged on eop=0 beats. For `NUM_INPUTS`=1 the pointer stays 0.
- Output:
  - `valid_out = (count != 0)`; data/eop/sel come from the FIFO head.
  - Pop when `valid_out && ready_out`.
- Push and pop in the same cycle leave `count` unchanged. The new beat enters behind the head, so order is preserved.
- `busy = (count != 0) || locked`.
- Reset (async, `reset` low) forces:
  - `count=0`, `valid_out=0`, `rr_ptr=0`, `locked=0`, `lock_idx=0`.
  - `data_out=0`, `eop_out=0`, `sel_out=0`, `busy=0`, `ready_in=0`.
- A reset mid-packet discards the lock and buffered beats. After reset deassertion, arbitration restarts from input 0.

## Timing
- Latency: a beat accepted in cycle N is presented on `valid_out` in cycle N+1 when the FIFO was empty. Otherwise it follows the buffered beats in order.
- Throughput: one beat per cycle while `ready_out` is held high, with `count` steady at 1.
- Backpressure:
  - `ready_out` low for 2+ cycles fills the FIFO (`count=2`).
  - `ready_in` drops to 0 in the cycle after the second push.
  - It returns to 1 in the cycle after the first pop.
- `valid_out`, `data_out`, `eop_out` and `sel_out` are stable while `valid_out && !ready_out`.
- Upstream must hold `valid_in`/`data_in` stable until `ready_in`. This block does not check that.
- Lock and pointer updates take effect for the grant decision in the cycle after the accepting edge.

## Test plan
- Reset: hold `reset` low with all `valid_in`=1 → `ready_in`=0, `valid_out`=0, `busy`=0. Release → the first grant goes to input 0, then 1, 2 in successive cycles with single-beat packets.
- Fairness: inputs 1, 3, 4 continuously valid with eop=1, `ready_out`=1 → `sel_out` sequence 1, 3, 4, 1, 3, 4…, one beat per cycle.
- Packet lock: input 2 sends a 4-beat packet (eop on beat 4) while input 0 is valid throughout → output sel 2, 2, 2, 2, then 0. A gap of 3 cycles inserted in input 2's packet → no input-0 beat is interleaved.
- Backpressure: stream from input 5, `ready_out`=0 for 5 cycles → `count` reaches 2 and `ready_in[5]` falls. On release, beats exit in original order with no loss or duplication.
- Simultaneous push/pop at `count`=2: pop and resumed acceptance in adjacent cycles → scoreboard shows exact order; `busy` falls only after the last eop beat drains.
- Mid-packet reset: assert reset after beat 2 of a 4-beat packet from input 3 → `valid_out`=0 and `locked`=0 immediately. After release, input 0 (if valid) is granted first.

Source files
------------

// File: rtl/sfu_commit_arbiter.sv
// rtl/sfu_commit_arbiter.sv - packet-aware round-robin merge of SFU commit responses into one stream
// Multi-beat packets keep the grant until eop; a 2-entry buffer decouples ready_in from ready_out.
module sfu_commit_arbiter #(
    parameter int NUM_INPUTS = 6,
    parameter int DATAW      = 64,
    parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    input  logic [NUM_INPUTS-1:0]       eop_in,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [DATAW-1:0]            data_out,
    output logic                        eop_out,
    output logic [SEL_W-1:0]            sel_out,
    output logic                        busy
);

    logic [SEL_W-1:0] rr_ptr_q;
    logic             locked_q;
    logic [SEL_W-1:0] lock_idx_q;
    logic [1:0]       count_q, count_d;
    logic [DATAW-1:0] head_data_q, tail_data_q;
    logic             head_eop_q, tail_eop_q;
    logic [SEL_W-1:0] head_sel_q, tail_sel_q;

    logic             space;
    logic             cand_valid;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] scan_sel;
    logic [SEL_W-1:0] next_ptr;
    logic             push, pop;
    logic [DATAW-1:0] push_data;
    logic             push_eop;
    int               idx;

    // Space depends on registered occupancy only, so ready_out never reaches ready_in.
    assign space = (count_q != 2'd2);

    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        idx        = 0;
        scan_sel   = '0;
        if (locked_q) begin
            cand       = lock_idx_q;
            cand_valid = valid_in[lock_idx_q];
        end else begin
            // Descending scan so the lowest offset from rr_ptr is the final winner.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
                scan_sel = SEL_W'(idx);
                if (valid_in[scan_sel]) begin
                    cand_valid = 1'b1;
                    cand       = scan_sel;
                end
            end
        end
    end

    assign push      = reset && space && cand_valid;
    assign pop       = valid_out && ready_out;
    assign push_data = data_in[int'(cand)*DATAW +: DATAW];
    assign push_eop  = eop_in[cand];
    assign next_ptr  = (cand == SEL_W'(NUM_INPUTS - 1)) ? '0 : cand + SEL_W'(1);

    always_comb begin
        ready_in = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push && cand == SEL_W'(i)) ready_in[i] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (!push && pop) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            locked_q    <= 1'b0;
            lock_idx_q  <= '0;
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_eop_q  <= 1'b0;
            head_sel_q  <= '0;
            tail_data_q <= '0;
            tail_eop_q  <= 1'b0;
            tail_sel_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                locked_q   <= !push_eop;
                lock_idx_q <= cand;
                if (push_eop) rr_ptr_q <= next_ptr;
            end
            // Head always holds the oldest beat; a simultaneous push lands behind it.
            if (push && !pop) begin
                if (count_q == 2'd0) begin
                    head_data_q <= push_data;
                    head_eop_q  <= push_eop;
                    head_sel_q  <= cand;
                end else begin
                    tail_data_q <= push_data;
                    tail_eop_q  <= push_eop;
                    tail_sel_q  <= cand;
                end
            end else if (!push && pop) begin
                head_data_q <= tail_data_q;
                head_eop_q  <= tail_eop_q;
                head_sel_q  <= tail_sel_q;
            end else if (push && pop) begin
                if (count_q == 2'd1) begin
                    head_data_q <= push_data;
                    head_eop_q  <= push_eop;
                    head_sel_q  <= cand;
                end else begin
                    head_data_q <= tail_data_q;
                    head_eop_q  <= tail_eop_q;
                    head_sel_q  <= tail_sel_q;
                    tail_data_q <= push_data;
                    tail_eop_q  <= push_eop;
                    tail_sel_q  <= cand;
                end
            end
        end
    end

    assign valid_out = (count_q != 2'd0);
    assign data_out  = head_data_q;
    assign eop_out   = head_eop_q;
    assign sel_out   = head_sel_q;
    assign busy      = (count_q != 2'd0) || locked_q;

endmodule

// File: tb/tb_sfu_commit_arbiter.sv
// tb/tb_sfu_commit_arbiter.sv - scoreboard and vector-table bench for sfu_commit_arbiter
module tb_sfu_commit_arbiter;

    localparam int N = 6;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   valid_in = '0;
    logic [N-1:0]   ready_in;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   eop_in = '0;
    logic           valid_out;
    logic           ready_out = 1'b0;
    logic [W-1:0]   data_out;
    logic           eop_out;
    logic [2:0]     sel_out;
    logic           busy;

    sfu_commit_arbiter #(.NUM_INPUTS(N), .DATAW(W)) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .eop_in(eop_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .eop_out(eop_out), .sel_out(sel_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        eop;
        logic [2:0]  sel;
    } beat_t;

    typedef struct {
        logic [5:0]      mask;
        logic [5:0][2:0] sel;
    } scen_t;

    beat_t  src_q [N][$];
    beat_t  exp_q [$];
    int     obs_sel [$];
    int     pop_tick [$];
    logic [N-1:0] hold = '0;
    bit     ro_fixed = 1'b0;
    bit     ro_rand = 1'b0;
    bit     acc_open = 1'b0;
    int     acc_sel = 0;
    int     tick_cnt = 0;
    int     out_cnt = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    scen_t  tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_beat(input int i, input logic [63:0] d, input logic e);
        beat_t b;
        b.data = d;
        b.eop  = e;
        b.sel  = 3'(i);
        src_q[i].push_back(b);
    endtask

    function automatic bit srcs_busy();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                valid_in[i]        = 1'b1;
                data_in[i*W +: W]  = src_q[i][0].data;
                eop_in[i]          = src_q[i][0].eop;
            end else begin
                valid_in[i]        = 1'b0;
                data_in[i*W +: W]  = '0;
                eop_in[i]          = 1'b0;
            end
        end
        ready_out = ro_rand ? ($urandom_range(0, 9) < 7) : ro_fixed;
    endtask

    task automatic sample();
        beat_t e;
        if (valid_out && ready_out) begin
            out_cnt++;
            pop_tick.push_back(tick_cnt);
            obs_sel.push_back(int'(sel_out));
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", data_out, e.data);
                chk("out_eop_sel", {60'd0, eop_out, sel_out}, {60'd0, e.eop, e.sel});
            end
        end
        chk("ready_onehot", 64'($onehot0(ready_in)), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (ready_in[i]) begin
                if (!valid_in[i] || src_q[i].size() == 0) begin
                    chk("ready_without_valid", 64'd1, 64'd0);
                end else begin
                    if (acc_open) chk("packet_atomic", 64'(i), 64'(acc_sel));
                    acc_open = !src_q[i][0].eop;
                    acc_sel  = i;
                    exp_q.push_back(src_q[i][0]);
                    void'(src_q[i].pop_front());
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
        tick_cnt++;
    endtask

    task automatic rst_assert();
        reset = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        obs_sel.delete();
        pop_tick.delete();
        hold     = '0;
        acc_open = 1'b0;
        ro_rand  = 1'b0;
    endtask

    task automatic rst_release();
        drive();
        #1;
        chk("rst_ready_in", 64'(ready_in), 64'd0);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outputs", {eop_out, sel_out, data_out[59:0]}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((srcs_busy() || exp_q.size() > 0) && n < bound) begin
            tick();
            n++;
            #1;
            if (exp_q.size() > 0) chk("busy_while_buffered", 64'(busy), 64'd1);
        end
        chk("drain_timeout", 64'(n < bound), 64'd1);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid_out", 64'(valid_out), 64'd0);
    endtask

    task automatic set_row(input int r, input logic [5:0] m, input int s0, input int s1,
                           input int s2, input int s3, input int s4, input int s5);
        tbl[r].mask   = m;
        tbl[r].sel[0] = 3'(s0);
        tbl[r].sel[1] = 3'(s1);
        tbl[r].sel[2] = 3'(s2);
        tbl[r].sel[3] = 3'(s3);
        tbl[r].sel[4] = 3'(s4);
        tbl[r].sel[5] = 3'(s5);
    endtask

    initial begin
        set_row(0, 6'b111111, 0, 1, 2, 3, 4, 5);
        set_row(1, 6'b011010, 1, 3, 4, 1, 3, 4);
        set_row(2, 6'b100001, 0, 5, 0, 5, 0, 5);
        set_row(3, 6'b000100, 2, 2, 2, 2, 2, 2);
        set_row(4, 6'b101100, 2, 3, 5, 2, 3, 5);

        // Round-robin order and full throughput from a fresh reset.
        for (int r = 0; r < 5; r++) begin
            int n;
            rst_assert();
            for (int i = 0; i < N; i++)
                if (tbl[r].mask[i])
                    for (int k = 0; k < 8; k++) add_beat(i, {32'(i), 32'(k)}, 1'b1);
            ro_fixed = 1'b1;
            rst_release();
            n = 0;
            while (obs_sel.size() < 6 && n < 40) begin
                tick();
                n++;
            end
            chk("scen_outputs", 64'(obs_sel.size() >= 6), 64'd1);
            if (obs_sel.size() >= 6) begin
                for (int k = 0; k < 6; k++) chk($sformatf("scen%0d_sel%0d", r, k), 64'(obs_sel[k]), 64'(tbl[r].sel[k]));
                chk("scen_throughput", 64'(pop_tick[5] - pop_tick[0]), 64'd5);
            end
        end

        // Packet lock across a 3-cycle gap while input 0 is waiting.
        rst_assert();
        for (int k = 0; k < 4; k++) add_beat(2, 64'h2000 + 64'(k), k == 3);
        for (int k = 0; k < 3; k++) add_beat(0, 64'h0100 + 64'(k), 1'b1);
        hold[0]  = 1'b1;
        ro_fixed = 1'b1;
        rst_release();
        tick();
        hold[0] = 1'b0;
        drive();
        tick();
        hold[2] = 1'b1;
        drive();
        for (int g = 0; g < 3; g++) begin
            #1;
            chk("lock_gap_ready", 64'(ready_in), 64'd0);
            chk("lock_gap_busy", 64'(busy), 64'd1);
            tick();
        end
        hold[2] = 1'b0;
        drive();
        drain(100);
        chk("lock_out_count", 64'(obs_sel.size()), 64'd7);
        if (obs_sel.size() == 7)
            for (int k = 0; k < 7; k++) chk($sformatf("lock_sel%0d", k), 64'(obs_sel[k]), (k < 4) ? 64'd2 : 64'd0);

        // Backpressure: fill the buffer, hold it, then release with alternating ready_out.
        rst_assert();
        for (int k = 0; k < 6; k++) add_beat(5, 64'h5000 + 64'(k), k == 5);
        ro_fixed = 1'b0;
        rst_release();
        tick();
        #1;
        chk("bp_ready_after_push1", 64'(ready_in), 64'b100000);
        chk("bp_valid_after_push1", 64'(valid_out), 64'd1);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_full_ready", 64'(ready_in), 64'd0);
            chk("bp_head_data", data_out, 64'h5000);
            chk("bp_head_sel", 64'(sel_out), 64'd5);
            tick();
        end
        #1;
        chk("bp_full_ready5", 64'(ready_in), 64'd0);
        ro_fixed = 1'b1;
        drive();
        tick();
        #1;
        chk("bp_ready_after_pop", 64'(ready_in), 64'b100000);
        chk("bp_head_after_pop", data_out, 64'h5001);
        for (int c = 0; c < 6; c++) begin
            ro_fixed = c[0];
            drive();
            tick();
        end
        ro_fixed = 1'b1;
        drive();
        drain(100);
        chk("bp_beats", 64'(obs_sel.size()), 64'd6);

        // Reset in the middle of a packet drops the lock; input 0 wins first afterwards.
        rst_assert();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) add_beat(3, 64'h3000 + 64'(k), k == 3);
        ro_fixed = 1'b1;
        drive();
        tick();
        tick();
        rst_assert();
        #1;
        chk("mid_rst_valid_out", 64'(valid_out), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 2; k++) begin
            add_beat(0, 64'h0A00 + 64'(k), 1'b1);
            add_beat(3, 64'h3A00 + 64'(k), 1'b1);
        end
        ro_fixed = 1'b1;
        rst_release();
        #1;
        chk("post_rst_grant", 64'(ready_in), 64'b000001);
        drain(100);
        chk("post_rst_count", 64'(obs_sel.size()), 64'd4);
        if (obs_sel.size() == 4) begin
            chk("post_rst_sel0", 64'(obs_sel[0]), 64'd0);
            chk("post_rst_sel1", 64'(obs_sel[1]), 64'd3);
        end

        // Random packets and random backpressure against the scoreboard.
        begin
            int total;
            int cnt0;
            rst_assert();
            total = 0;
            for (int i = 0; i < N; i++)
                for (int p = 0; p < 3; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        add_beat(i, {16'(i), 16'(p), 32'($urandom)}, k == len - 1);
                        total++;
                    end
                end
            rst_release();
            ro_rand = 1'b1;
            drive();
            cnt0 = out_cnt;
            drain(3000);
            chk("rand_beats", 64'(out_cnt - cnt0), 64'(total));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
